// File: rtl/matmul_pcpi_sequencer.sv
// Host-side sequencer for the 3x3 fused matmul PCPI coprocessor: buffers operands,
// reloads only entries that changed, then issues start and clear and captures C.
module matmul_pcpi_sequencer #(
    parameter int NUM_WORDS = 27,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_we,
    input  logic [4:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              go,
    input  logic              go_full,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [8:0]        result,
    input  logic [8:0]        mm_c,
    output logic              pcpi_valid,
    output logic [31:0]       pcpi_insn,
    input  logic              pcpi_ready,
    input  logic              pcpi_wait
);
    localparam int PTR_W  = $clog2(NUM_WORDS);
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W-1:0]  LAST   = PTR_W'(NUM_WORDS - 1);
    localparam logic [TCNT_W-1:0] TC_MAX = TCNT_W'(TIMEOUT - 1);
    localparam logic [6:0]        OPC    = 7'b0001011;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_LOAD, S_START, S_CLEAR, S_DONE, S_ERR
    } state_t;

    state_t                  r_state, w_next;
    logic [DATA_W-1:0]       r_buf [NUM_WORDS];
    logic [NUM_WORDS-1:0]    r_dirty;
    logic [PTR_W-1:0]        r_ptr;
    logic [TCNT_W-1:0]       r_tcnt;
    logic                    r_valid;
    logic [31:0]             r_insn;
    logic [8:0]              r_result;
    logic [31:0]             w_insn;
    logic                    w_acc, w_tmo, w_last, w_wr, w_issue;
    logic                    w_unused;

    assign w_unused = pcpi_wait;

    assign busy       = (r_state == S_SCAN) || (r_state == S_LOAD) ||
                        (r_state == S_START) || (r_state == S_CLEAR);
    assign done       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign result     = r_result;
    assign pcpi_valid = r_valid;
    assign pcpi_insn  = r_insn;

    assign w_acc   = r_valid && pcpi_ready;
    assign w_tmo   = r_valid && !pcpi_ready && (r_tcnt == TC_MAX);
    assign w_last  = (r_ptr == LAST);
    assign w_wr    = ld_we && !busy && (32'(ld_addr) < NUM_WORDS);
    assign w_issue = (r_state == S_LOAD) || (r_state == S_START) || (r_state == S_CLEAR);

    always_comb begin
        w_insn = '0;
        case (r_state)
            S_LOAD:  w_insn = {1'b0, r_buf[r_ptr], 3'b000, r_ptr, OPC};
            S_START: w_insn = {1'b0, 16'd0, 3'b111, 5'd0, OPC};
            S_CLEAR: w_insn = {1'b0, 16'd0, 3'b101, 5'd0, OPC};
            default: w_insn = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (go) w_next = S_SCAN;
            S_SCAN:  begin
                if (r_dirty[r_ptr]) w_next = S_LOAD;
                else if (w_last)    w_next = S_START;
            end
            S_LOAD:  begin
                if (w_acc)      w_next = w_last ? S_START : S_SCAN;
                else if (w_tmo) w_next = S_ERR;
            end
            S_START: begin
                if (w_acc)      w_next = S_CLEAR;
                else if (w_tmo) w_next = S_ERR;
            end
            S_CLEAR: begin
                if (w_acc)      w_next = S_DONE;
                else if (w_tmo) w_next = S_ERR;
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr) r_buf[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dirty  <= '1;
            r_ptr    <= '0;
            r_tcnt   <= '0;
            r_valid  <= 1'b0;
            r_insn   <= '0;
            r_result <= '0;
        end else begin
            if ((r_state == S_IDLE && go && go_full) || r_state == S_ERR)
                r_dirty <= '1;
            else if (r_state == S_LOAD && w_acc)
                r_dirty[r_ptr] <= 1'b0;
            if (w_wr) r_dirty[ld_addr] <= 1'b1;

            if (r_state == S_IDLE && go)
                r_ptr <= '0;
            else if (r_state == S_SCAN && !r_dirty[r_ptr] && !w_last)
                r_ptr <= r_ptr + 1'b1;
            else if (r_state == S_LOAD && w_acc && !w_last)
                r_ptr <= r_ptr + 1'b1;

            // Each issuing state enters with valid low, which guarantees the idle
            // gap between instructions; the insn word is latched only on the rise.
            if (w_issue) begin
                if (!r_valid) begin
                    r_valid <= 1'b1;
                    r_insn  <= w_insn;
                    r_tcnt  <= '0;
                end else if (pcpi_ready || w_tmo) begin
                    r_valid <= 1'b0;
                end else begin
                    r_tcnt <= r_tcnt + 1'b1;
                end
            end else begin
                r_valid <= 1'b0;
            end

            if (r_state == S_START && w_acc) r_result <= mm_c;
        end
    end
endmodule

// File: doc/matmul_pcpi_sequencer.md
Name: matmul_pcpi_sequencer

Overview:
Host-side controller that drives the 3x3 fused matrix-multiply PCPI coprocessor (custom opcode 7'b0001011).
- Buffers A, B and bias operands locally and tracks which entries changed since the last run.
- On `go`, issues one load instruction per changed entry, then a start instruction, captures the 9-bit thresholded result, and issues a clear instruction.
- Sits between a host register interface and the coprocessor's PCPI port; replaces hand-written firmware load/start loops.

Parameters:
NUM_WORDS, 27, operand entries (0-8 A row-major, 9-17 B, 18-26 bias)
DATA_W, 16, operand width (signed, carried in insn[30:15])
TIMEOUT, 32, max cycles waiting for pcpi_ready per instruction before abort

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ld_we  in  1  host write strobe into operand buffer
ld_addr  in  5  operand index 0..26
ld_data  in  16  operand value
go  in  1  start job (sampled in IDLE only)
go_full  in  1  with go: mark all 27 entries dirty before sequencing
busy  out  1  high from accepted go until DONE/ERR exit
done  out  1  one-cycle pulse, job completed
err  out  1  one-cycle pulse, job aborted on timeout
result  out  9  captured C bits, bit 3*i+j = C[i][j]
mm_c  in  9  coprocessor C matrix bits, same packing
pcpi_valid  out  1  instruction valid to coprocessor
pcpi_insn  out  32  instruction word
pcpi_ready  in  1  coprocessor completion
pcpi_wait  in  1  coprocessor busy (monitored only)

Behaviour:
- Reset (async, resetn=0): state IDLE; pcpi_valid=0, pcpi_insn=0, busy=0, done=0, err=0, result=0, all dirty bits=1, scan pointer=0, timeout counter=0. Buffer contents are not reset.
- Instruction encoding:
  - [6:0]=7'b0001011
  - [11:7]=address
  - [14:12]=funct3
  - [30:15]=value
  - [31]=0
  - Load: funct3=000, address=entry, value=buffer[entry].
  - Start: funct3=111, address=0, value=0.
  - Clear: funct3=101, address=0, value=0.
- Host writes:
  - Accepted only when busy=0 and ld_addr<27. A write sets the entry's dirty bit.
  - Writes while busy=1, or with ld_addr>=27, are ignored silently.
  - Write and go in the same IDLE cycle: the write is applied and the entry is dirty for that job.
- States:
  - IDLE: on go -> SCAN, busy=1, pointer=0. If go_full, all dirty bits set.
  - SCAN: one entry examined per cycle.
    - Dirty entry -> LOAD.
    - Clean entry -> pointer+1.
    - After entry 26 -> START.
    - Zero dirty entries -> START after 27 cycles.
  - LOAD: pcpi_valid=1 with the load insn, held stable until pcpi_ready=1. On that cycle, clear the dirty bit and drop pcpi_valid next cycle. Then pointer+1 -> SCAN (or START after entry 26).
  - START: pcpi_valid=1 with the start insn until pcpi_ready=1. On that cycle, result<=mm_c -> CLEAR.
  - CLEAR: pcpi_valid=1 with the clear insn until pcpi_ready=1 -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
  - ERR: err=1 for one cycle, busy=0, pcpi_valid=0. All dirty bits set, so the next job reloads everything. Result unchanged -> IDLE.
- Handshake: at least one idle cycle with pcpi_valid=0 between consecutive instructions. pcpi_insn changes only while pcpi_valid=0 or in the cycle valid rises.
- Timeout:
  - The counter clears on each pcpi_valid rise and increments each cycle while valid=1 and ready=0.
  - Reaching TIMEOUT in LOAD/START/CLEAR -> ERR.
  - pcpi_ready in the same cycle as the counter reaching TIMEOUT counts as success.
- go while busy: ignored.
- Reset mid-job: immediate return to IDLE, pcpi_valid dropped asynchronously. The coprocessor holds its own reset separately.

Test Plan:
- Reset, write all 27 entries (A=identity, B=[[1,2,3],[4,5,6],[7,8,9]], bias=-100 everywhere), go; coprocessor model returns ready 1 cycle after valid -> 27 load insns with addresses 0..26 in order (e.g. entry 9 insn=32'h0000_848B), then start 32'h0000_700B, then clear 32'h0000_500B. With mm_c=9'h1FF: result=9'h1FF, done pulses once, busy falls same cycle.
- After the first job, rewrite only entries 4 and 20, go -> exactly two load insns (addresses 4, 20), then start and clear; done pulses.
- Repeat go with no writes and go_full=0 -> no loads; start issued 27 SCAN cycles after go.
- Coprocessor model never asserts ready on the start insn -> err pulses 32 cycles after valid rise, pcpi_valid=0 afterwards, next go reloads all 27 entries.
- ld_we with ld_addr=27, and ld_we while busy -> buffer and dirty bits unchanged. go asserted during a job is ignored (single done pulse).
- Assert resetn=0 mid-LOAD -> pcpi_valid=0 and busy=0 without a clock edge; after release, state is IDLE and all dirty bits are set.
